doorbell_seq: RTL and testbench

DOORBELL_SEQ -- requirements
Module: doorbell_seq

---
 rtl/doorbell_seq.sv | 137 +++++++++++++
 tb/tb_doorbell_seq.sv | 130 +++++++++++++
 2 files changed

// File: rtl/doorbell_seq.sv
// Two-tone doorbell chime: plays a "ding" channel, a silent gap, then a "dong"
// channel. The selected live sample stream is passed through a fixed-latency register line.
//
// state | meaning
// IDLE  | waiting for press; mux outputs 0
// DING  | first tone, sounds[latched sel_a] for TONE_LEN cycles
// GAP   | silence for GAP_LEN cycles
// DONG  | second tone, sounds[latched sel_b] for TONE_LEN cycles
module doorbell_seq #(
    parameter int WIDTH    = 8,
    parameter int SEL_W    = 2,
    parameter int DELAY    = 5,
    parameter int TONE_LEN = 16,
    parameter int GAP_LEN  = 4,
    parameter int RETRIG   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [(2**SEL_W)*WIDTH-1:0]   sounds,
    input  logic                          press,
    input  logic [SEL_W-1:0]              sel_a,
    input  logic [SEL_W-1:0]              sel_b,
    output logic [WIDTH-1:0]              out,
    output logic                          busy,
    output logic                          done
);

    localparam int NSRC   = 2**SEL_W;
    localparam int MAXLEN = (TONE_LEN > GAP_LEN) ? TONE_LEN : GAP_LEN;
    localparam int CNT_W  = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DING = 2'd1,
        S_GAP  = 2'd2,
        S_DONG = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sela_q, sela_d;
    logic [SEL_W-1:0]   selb_q, selb_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   chan [NSRC];
    logic [WIDTH-1:0]   dly_q [DELAY];

    for (genvar i = 0; i < NSRC; i++) begin : g_chan
        assign chan[i] = sounds[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sela_q  <= '0;
            selb_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sela_q  <= sela_d;
            selb_q  <= selb_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        sela_d  = sela_q;
        selb_d  = selb_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: cnt_d = '0;
            S_DING: begin
                if (cnt_q == TONE_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_DONG;
                    cnt_d   = '0;
                end
            end
            S_DONG: begin
                if (cnt_q == TONE_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A (re)start overrides everything above, including a completing DONG.
        if (press && (state_q == S_IDLE || RETRIG != 0)) begin
            state_d = S_DING;
            cnt_d   = '0;
            sela_d  = sel_a;
            selb_d  = sel_b;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        m = '0;
        case (state_q)
            S_DING:  m = chan[sela_q];
            S_DONG:  m = chan[selb_q];
            default: m = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= m;
            for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign out  = dly_q[DELAY-1];
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_doorbell_seq.sv
// Scenario bench for doorbell_seq: two instances (RETRIG=0 and RETRIG=1) share stimulus;
// per-cycle expectations come from the chime timelines and go through a scoreboard queue.
module tb_doorbell_seq;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] out;
        logic         busy;
        logic         done;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [4*W-1:0] sounds;
    logic           press;
    logic [1:0]     sel_a, sel_b;
    logic [W-1:0]   out0, out1;
    logic           busy0, busy1, done0, done1;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    doorbell_seq #(.WIDTH(8), .SEL_W(2), .DELAY(5), .TONE_LEN(4), .GAP_LEN(2), .RETRIG(0)) u_r0 (
        .clk(clk), .rst(rst), .sounds(sounds), .press(press), .sel_a(sel_a), .sel_b(sel_b),
        .out(out0), .busy(busy0), .done(done0)
    );

    doorbell_seq #(.WIDTH(8), .SEL_W(2), .DELAY(5), .TONE_LEN(4), .GAP_LEN(2), .RETRIG(1)) u_r1 (
        .clk(clk), .rst(rst), .sounds(sounds), .press(press), .sel_a(sel_a), .sel_b(sel_b),
        .out(out1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Expected response from the documented chime timelines (cycle 0 follows the press edge).
    function automatic exp_t expect_at(input int scn, input int c);
        exp_t e;
        e.busy = in_rng(c, 0, 9);
        e.done = (c == 10);
        e.out  = in_rng(c, 5, 8) ? 8'h22 : in_rng(c, 11, 14) ? 8'h44 : 8'h00;
        case (scn)
            3: begin
                e.busy = in_rng(c, 0, 15);
                e.done = (c == 16);
                e.out  = in_rng(c, 5, 8)   ? 8'h22 :
                         in_rng(c, 11, 14) ? 8'h33 :
                         in_rng(c, 17, 20) ? 8'h11 : 8'h00;
            end
            4: if (c >= 7) e = '0;
            5: if (in_rng(c, 7, 8)) e.out = 8'h55;
            6: begin
                e.busy = in_rng(c, 0, 9) || in_rng(c, 11, 20);
                e.done = (c == 10) || (c == 21);
                e.out  = (in_rng(c, 5, 8) || in_rng(c, 16, 19))  ? 8'h22 :
                         (in_rng(c, 11, 14) || in_rng(c, 22, 25)) ? 8'h44 : 8'h00;
            end
            default: ;
        endcase
        if (c < 0) e = '0;
        return e;
    endfunction

    task automatic run_scn(input int scn);
        exp_t e;
        rst    = 1'b1;
        press  = 1'b0;
        sel_a  = 2'd0;
        sel_b  = 2'd0;
        sounds = {8'h44, 8'h33, 8'h22, 8'h11};
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int c = -2; c <= 27; c++) begin
            rst   = (scn == 4 && c == 6);
            press = (c == -1) || (scn == 2 && c == 3) || (scn == 3 && c == 5) ||
                    (scn == 6 && c <= 10 && c >= -1);
            if (c == -1) begin
                sel_a = 2'd1;
                sel_b = 2'd3;
            end
            if ((scn == 2 || scn == 3) && c == (scn == 2 ? 3 : 5)) begin
                sel_a = 2'd2;
                sel_b = 2'd0;
            end
            if (scn == 5 && c == 2) sounds = {8'h44, 8'h33, 8'h55, 8'h11};
            sb.push_back(expect_at(scn, c));

            @(negedge clk);
            chk($sformatf("s%0d c%0d sb_depth", scn, c), sb.size(), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (scn == 3) begin
                    chk($sformatf("s%0d c%0d out", scn, c), out1, e.out);
                    chk($sformatf("s%0d c%0d busy", scn, c), busy1, e.busy);
                    chk($sformatf("s%0d c%0d done", scn, c), done1, e.done);
                end else begin
                    chk($sformatf("s%0d c%0d out", scn, c), out0, e.out);
                    chk($sformatf("s%0d c%0d busy", scn, c), busy0, e.busy);
                    chk($sformatf("s%0d c%0d done", scn, c), done0, e.done);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst    = 1'b1;
        press  = 1'b0;
        sel_a  = 2'd0;
        sel_b  = 2'd0;
        sounds = '0;
        for (int s = 1; s <= 6; s++) run_scn(s);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
